// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_e  : fetch FSM encoding (IDLE, READ, WRITE)
//   FETCH_DATA_W   : default instruction word width
//   ROM_WORDS      : number of words in the instruction ROM image
//   rom_word()     : ROM contents lookup; words outside the image read as 0
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } fetch_state_e;

  localparam int FETCH_DATA_W = 16;
  localparam int ROM_WORDS    = 4;

  function automatic logic [15:0] rom_word(input int unsigned idx);
    logic [15:0] w;
    case (idx)
      0:       w = 16'h1A01;
      1:       w = 16'h2B02;
      2:       w = 16'h3C03;
      3:       w = 16'h4D04;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry in-order buffer between the fetch FSM and decode.
//   clk, reset (sync, active-low)
//   push, din    : write an entry; accepted when not full, or when full with a pop
//   pop          : remove the head entry (ignored when empty)
//   flush        : empty the buffer at this edge
//   dout         : head entry (meaningful only while empty=0)
//   full, empty  : occupancy flags
module fetch_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, wr_ptr == rd_ptr: a simultaneous push reuses the slot being popped.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instruction words from a small ROM for byte-address
// requests from the PC stage and queues them for decode.
//   clk, reset (sync, active-low)
//   pc_i, pc_valid_i     : request strobe; pc_i must be word aligned
//   flush_i              : drop everything pending/buffered (a strobe in the
//                          same cycle still starts a fresh fetch)
//   instr_ready_i        : decode accepts the head entry
//   instr_o, instr_pc_o, instr_valid_o : head entry of the output buffer
//   misalign_o           : one-cycle pulse after a rejected misaligned strobe
//   busy_o               : FSM active or a request waiting
//   state_dbg            : current FSM state
// Handshake: an entry transfers on a clock edge where instr_valid_o and
// instr_ready_i are both 1; the head stays stable until it transfers.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ANCHO  = 4,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ANCHO-1:0]  pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ANCHO-1:0]  instr_pc_o,
  output logic              instr_valid_o,
  output logic              misalign_o,
  output logic              busy_o,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state, next_state;
  logic [ANCHO-1:0]  req_pc;
  logic [DATA_W-1:0] word;
  logic              pend_valid;
  logic [ANCHO-1:0]  pend_pc;
  logic              misalign_q;

  logic              aligned_req;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ANCHO+DATA_W-1:0] fifo_dout;

  assign aligned_req = pc_valid_i && (pc_i[1:0] == 2'b00);
  assign pop         = instr_valid_o && instr_ready_i;
  assign push_ok     = !fifo_full || pop;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush overrides, but a same-cycle strobe restarts a fetch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (aligned_req) next_state = ST_READ;
      ST_READ:  next_state = ST_WRITE;
      ST_WRITE: if (push_ok) next_state = (aligned_req || pend_valid) ? ST_READ : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (flush_i) next_state = aligned_req ? ST_READ : ST_IDLE;
  end

  // Output logic
  always_comb begin
    push   = (state == ST_WRITE) && push_ok && !flush_i;
    busy_o = (state != ST_IDLE) || pend_valid;
  end

  // Request / word / pending datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_pc     <= '0;
      word       <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= pc_valid_i && (pc_i[1:0] != 2'b00);
      if (flush_i) begin
        pend_valid <= 1'b0;
        if (aligned_req) req_pc <= pc_i;
      end else begin
        case (state)
          ST_IDLE: if (aligned_req) req_pc <= pc_i;
          ST_READ: begin
            word <= DATA_W'(rom_word(32'(req_pc[ANCHO-1:2])));
            if (aligned_req) begin
              pend_valid <= 1'b1;
              pend_pc    <= pc_i;
            end
          end
          ST_WRITE: begin
            if (push_ok) begin
              // A strobe arriving now is newer than anything pending.
              if (aligned_req)     req_pc <= pc_i;
              else if (pend_valid) req_pc <= pend_pc;
              pend_valid <= 1'b0;
            end else if (aligned_req) begin
              pend_valid <= 1'b1;
              pend_pc    <= pc_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fetch_fifo #(.W(ANCHO + DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush_i),
    .din   ({req_pc, word}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_dout[DATA_W-1:0];
  assign instr_pc_o    = fifo_dout[ANCHO+DATA_W-1:DATA_W];
  assign misalign_o    = misalign_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch (ANCHO=4, DATA_W=16).
module tb_instr_fetch;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pc_i;
  logic         pc_valid_i;
  logic         flush_i;
  logic         instr_ready_i;
  logic [15:0]  instr_o;
  logic [3:0]   instr_pc_o;
  logic         instr_valid_o;
  logic         misalign_o;
  logic         busy_o;
  fetch_state_e state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch #(.ANCHO(4), .DATA_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .flush_i       (flush_i),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .misalign_o    (misalign_o),
    .busy_o        (busy_o),
    .state_dbg     (state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] pc);
    pc_i = pc;
    pc_valid_i = 1'b1;
    step();
    pc_valid_i = 1'b0;
  endtask

  // Accept beats for a bounded number of cycles, comparing against exp_q.
  task automatic drain(input int budget);
    int extra;
    extra = 0;
    instr_ready_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid_o) begin
        if (exp_q.size() > 0) check("drain_beat", {12'h0, instr_pc_o, instr_o}, {12'h0, exp_q.pop_front()});
        else extra++;
      end
      step();
    end
    check("drain_left", 32'(exp_q.size()), 0);
    check("drain_extra", 32'(extra), 0);
  endtask

  initial begin
    reset = 1'b0; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
    repeat (2) step();
    check("rst_valid", instr_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", instr_pc_o, 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    step();

    // Single fetch of pc=4, two-edge latency, single beat
    instr_ready_i = 1'b1;
    pulse(4'h4);
    check("lat1_valid", instr_valid_o, 0);
    check("lat1_busy", busy_o, 1);
    check("lat1_state", 32'(state_dbg), 32'(ST_READ));
    step();
    check("lat2_valid", instr_valid_o, 0);
    check("lat2_state", 32'(state_dbg), 32'(ST_WRITE));
    step();
    check("lat3_valid", instr_valid_o, 1);
    check("lat3_instr", instr_o, 16'h2B02);
    check("lat3_pc", instr_pc_o, 4'h4);
    step();
    check("single_beat", instr_valid_o, 0);
    check("single_busy", busy_o, 0);

    // Misaligned strobe
    pulse(4'h6);
    check("mis_pulse", misalign_o, 1);
    check("mis_busy", busy_o, 0);
    check("mis_valid", instr_valid_o, 0);
    step();
    check("mis_clear", misalign_o, 0);
    check("mis_valid2", instr_valid_o, 0);
    check("mis_busy2", busy_o, 0);

    // Backpressure: two buffered, third stalls in WRITE
    instr_ready_i = 1'b0;
    pulse(4'h0); repeat (3) step();
    pulse(4'h4); repeat (3) step();
    pulse(4'h8); repeat (2) step();
    check("bp_valid", instr_valid_o, 1);
    check("bp_head", instr_o, 16'h1A01);
    check("bp_head_pc", instr_pc_o, 4'h0);
    check("bp_busy", busy_o, 1);
    check("bp_stall", 32'(state_dbg), 32'(ST_WRITE));
    instr_ready_i = 1'b1;
    step();
    check("bp_beat2", instr_o, 16'h2B02);
    check("bp_idle", 32'(state_dbg), 32'(ST_IDLE));
    step();
    check("bp_beat3", instr_o, 16'h3C03);
    check("bp_beat3_pc", instr_pc_o, 4'h8);
    step();
    check("bp_empty", instr_valid_o, 0);
    check("bp_notbusy", busy_o, 0);

    // Pending overwrite: 0 accepted, 4 replaced by 8
    instr_ready_i = 1'b1;
    pc_i = 4'h0; pc_valid_i = 1'b1; step();
    pc_i = 4'h4; step();
    pc_i = 4'h8; step();
    pc_valid_i = 1'b0;
    exp_q.push_back({4'h0, 16'h1A01});
    exp_q.push_back({4'h8, 16'h3C03});
    drain(8);

    // Flush during READ drops the word
    pulse(4'h0);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("flush_valid", instr_valid_o, 0);
    check("flush_state", 32'(state_dbg), 32'(ST_IDLE));
    check("flush_busy", busy_o, 0);
    drain(5);

    // Flush with same-cycle strobe: only the new request survives
    pulse(4'h8);
    flush_i = 1'b1; pc_i = 4'hC; pc_valid_i = 1'b1; step();
    flush_i = 1'b0; pc_valid_i = 1'b0;
    check("flushreq_state", 32'(state_dbg), 32'(ST_READ));
    exp_q.push_back({4'hC, 16'h4D04});
    drain(6);

    // Flush empties a full buffer
    instr_ready_i = 1'b0;
    pulse(4'h0); repeat (3) step();
    pulse(4'h4); repeat (3) step();
    check("fullbuf_head", instr_o, 16'h1A01);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("fullbuf_flushed", instr_valid_o, 0);
    drain(3);

    // Reset while holding two entries
    instr_ready_i = 1'b0;
    pc_i = 4'h0; pc_valid_i = 1'b1; step();
    pc_i = 4'h4; step();
    pc_valid_i = 1'b0;
    repeat (3) step();
    check("pre_rst_valid", instr_valid_o, 1);
    check("pre_rst_head", instr_o, 16'h1A01);
    check("pre_rst_idle", busy_o, 0);
    reset = 1'b0; step(); reset = 1'b1;
    check("mid_rst_valid", instr_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_instr", instr_o, 0);
    check("mid_rst_pc", instr_pc_o, 0);
    instr_ready_i = 1'b1;
    pulse(4'h0);
    exp_q.push_back({4'h0, 16'h1A01});
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ANCHO, default 4, PC/address width; the SHALL fetch ROM_DEPTH = 2^(ANCHO-2) words.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pc_i  input  ANCHO  byte address from PC stage, sampled only when pc_valid_i=1.
REQ-006 pc_valid_i  input  1  one-cycle strobe: PC stage has updated pc_i.
REQ-007 flush_i  input  1  discard all pending and buffered fetches (jump taken).
REQ-008 instr_ready_i  input  1  downstream decode accepts head entry.
REQ-009 instr_o  output  DATA_W  head-of-buffer instruction word.
REQ-010 instr_pc_o  output  ANCHO  byte address of instr_o.
REQ-011 instr_valid_o  output  1  head entry valid.
REQ-012 misalign_o  output  1  one-cycle pulse: rejected request with pc_i[1:0]!=0.
REQ-013 busy_o  output  1  high when FSM not IDLE or a request is pending.

Function
REQ-014 FSM states SHALL be IDLE, READ, WRITE.
REQ-015 IDLE: on pc_valid_i=1 with pc_i[1:0]=0, capture pc_i into req_pc and go to READ; otherwise remain in IDLE.
REQ-016 pc_valid_i with pc_i[1:0]!=0 SHALL not start a fetch and SHALL pulse misalign_o the following cycle.
REQ-017 READ: ROM word at index req_pc[ANCHO-1:2] SHALL be registered; next state WRITE unconditionally.
REQ-018 WRITE: push {req_pc, word} into output buffer if not full, or if full with a pop in the same cycle; then go to IDLE (or READ if a pending request exists); else hold WRITE (stall).
REQ-019 Latency: pc_valid_i sampled at edge N with FSM in IDLE and buffer not full -> instr_valid_o=1 after edge N+2.
REQ-020 pc_valid_i while FSM not IDLE SHALL load a 1-entry pending register; a later strobe overwrites it (latest wins).
REQ-021 Output buffer: 2-entry FIFO, in-order; pop when instr_valid_o & instr_ready_i; instr_o/instr_pc_o stable while valid and not popped.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; count SHALL never exceed 2 or underflow.
REQ-023 flush_i=1 SHALL, at that edge, empty the FIFO, clear pending, and force FSM to IDLE; an in-flight READ/WRITE word SHALL be dropped.
REQ-024 flush_i and pc_valid_i in the same cycle: flush applies, and the new pc_i SHALL be captured as a fresh request (FSM to READ).
REQ-025 Index arithmetic SHALL use pc bits [ANCHO-1:2] only; no wrap logic beyond natural ANCHO-bit width.

Reset
REQ-026 reset=0 at posedge clk SHALL set FSM=IDLE, FIFO count=0, pending cleared, instr_valid_o=0, misalign_o=0, busy_o=0, instr_o=0, instr_pc_o=0.
REQ-027 Reset mid-operation SHALL abort any fetch; no push SHALL occur on the reset edge.

Structure
REQ-028 Package fetch_pkg SHALL hold the state enum, DATA_W default, and ROM contents constant: ROM[0]=16'h1A01, ROM[1]=16'h2B02, ROM[2]=16'h3C03, ROM[3]=16'h4D04.
REQ-029 The 2-entry buffer SHALL be sub-module fetch_fifo (push, pop, flush, full, empty, head data).

Verification
REQ-030 pc_i=4'h4 strobe, ready=1 -> instr_valid_o after 2 edges, instr_o=16'h2B02, instr_pc_o=4'h4, single beat.
REQ-031 ready=0, strobes pc=0,4,8 spaced 4 cycles -> FIFO holds 1A01,2B02; third stalls in WRITE, busy_o=1; ready=1 -> 1A01,2B02,3C03 in order.
REQ-032 pc_i=4'h6 strobe -> misalign_o pulse once, instr_valid_o stays 0, busy_o stays 0.
REQ-033 Strobe pc=0, flush_i during READ -> no output; flush with strobe pc=4'hC same cycle -> only 4D04 emitted.
REQ-034 Strobes pc=0 (accepted) then 4 and 8 while busy -> outputs 1A01 then 3C03 (4 overwritten).
REQ-035 reset=0 while FIFO holds 2 entries -> next cycle instr_valid_o=0, busy_o=0; subsequent fetch of pc=0 yields 1A01.
